// File: rtl/mdu_iter.sv
// ----------------------------------------------------------------------------
// mdu_iter -- iterative multiply/divide unit with HI/LO result registers.
//
// A single-cycle-issue multiplier (product formed one cycle after accept) and
// a restoring divider that retires one quotient bit per cycle. Results land in
// the architectural HI/LO pair; MTHI/MTLO write HI/LO directly.
//
// Ports
//   clk        : clock
//   reset      : synchronous, active-high reset
//   req_valid  : request present
//   req_ready  : request accepted this cycle when high together with req_valid
//   req_op     : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO,
//                110/111 NOP
//   req_src1   : rs (dividend / multiplicand / MTHI-MTLO data)
//   req_src2   : rt (divisor / multiplier)
//   cancel     : flush; kills an in-flight MUL/DIV, blocks acceptance in IDLE
//   wr_block   : suppresses any HI/LO write on the edge it is high
//   busy       : an operation is in flight (state != IDLE)
//   done       : one-cycle completion pulse (state == DONE)
//   hi_rdata   : current HI register
//   lo_rdata   : current LO register
// ----------------------------------------------------------------------------
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_src1,
    input  logic [WIDTH-1:0] req_src2,
    input  logic             cancel,
    input  logic             wr_block,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_rdata,
    output logic [WIDTH-1:0] lo_rdata
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;      // multiplicand, or dividend/quotient shift register
    logic [WIDTH-1:0] b_q, b_d;      // multiplier, or divisor magnitude
    logic [WIDTH-1:0] rem_q, rem_d;  // partial remainder
    logic [CW-1:0]    cnt_q, cnt_d;  // quotient bits still to produce
    logic             qneg_q, qneg_d; // negate quotient at the end
    logic             rneg_q, rneg_d; // negate remainder at the end
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------
    logic             accept;
    logic             src1_neg, src2_neg;
    logic [WIDTH-1:0] src1_abs, src2_abs;
    logic             mul_signed;
    logic [2*WIDTH-1:0] a_ext, b_ext, product;
    logic [WIDTH:0]   shifted, diff;
    logic             ge;
    logic [WIDTH-1:0] quo_nxt, rem_nxt, quo_fix, rem_fix;

    always_comb begin
        // Magnitudes for signed divide; -MIN wraps to MIN, which is still the
        // correct unsigned magnitude 2^(WIDTH-1).
        src1_neg = (req_op == OP_DIV) && req_src1[WIDTH-1];
        src2_neg = (req_op == OP_DIV) && req_src2[WIDTH-1];
        src1_abs = src1_neg ? -req_src1 : req_src1;
        src2_abs = src2_neg ? -req_src2 : req_src2;

        // One 2W x 2W multiplier serves both MULT and MULTU: sign- or
        // zero-extend and keep the low 2W bits of the product.
        mul_signed = (op_q == OP_MULT);
        a_ext   = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q};
        b_ext   = {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
        product = a_ext * b_ext;

        // Restoring step: since rem < divisor, shifted < 2*divisor, so the
        // top bit of the W+1-bit difference is exactly the borrow.
        shifted = {rem_q, a_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        ge      = ~diff[WIDTH];
        rem_nxt = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_nxt = {a_q[WIDTH-2:0], ge};
        quo_fix = qneg_q ? -quo_nxt : quo_nxt;
        rem_fix = rneg_q ? -rem_nxt : rem_nxt;
    end

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        req_ready = (state_q == S_IDLE) && !cancel;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        accept    = req_valid && req_ready;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = req_op;
                    unique case (req_op)
                        OP_MULT, OP_MULTU: begin
                            a_d     = req_src1;
                            b_d     = req_src2;
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = src1_abs;
                            b_d     = src2_abs;
                            rem_d   = '0;
                            cnt_d   = CW'(WIDTH);
                            qneg_d  = src1_neg ^ src2_neg;
                            rneg_d  = src1_neg;
                            state_d = S_DIV;
                        end
                        OP_MTHI: begin
                            if (!wr_block) hi_d = req_src1;
                            state_d = S_DONE;
                        end
                        OP_MTLO: begin
                            if (!wr_block) lo_d = req_src1;
                            state_d = S_DONE;
                        end
                        default: state_d = S_DONE;  // NOP
                    endcase
                end
            end

            S_MUL: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (!wr_block) {hi_d, lo_d} = product;
                    state_d = S_DONE;
                end
            end

            S_DIV: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    a_d   = quo_nxt;
                    rem_d = rem_nxt;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        // Divide-by-zero keeps latency and the done pulse but
                        // leaves HI/LO untouched.
                        if (!wr_block && (b_q != '0)) begin
                            lo_d = quo_fix;
                            hi_d = rem_fix;
                        end
                        state_d = S_DONE;
                    end
                end
            end

            // Result is already committed, so cancel has nothing to kill here.
            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: non-blocking assignments only, so every flop samples the values
    // from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_rdata = hi_q;
    assign lo_rdata = lo_q;

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/HI/LO width; legal values are even and >= 4.
REQ-002 SHALL have ports clk input 1, the clock, and reset input 1, synchronous active-high reset.
REQ-003 SHALL have port req_valid input 1: request present.
REQ-004 SHALL have port req_ready output 1: request accepted this cycle when high together with req_valid.
REQ-005 SHALL have port req_op input 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 NOP.
REQ-006 SHALL have ports req_src1 and req_src2, each input WIDTH: rs (dividend/multiplicand) and rt (divisor/multiplier).
REQ-007 SHALL have port cancel input 1: exception/eret flush that kills the in-flight operation.
REQ-008 SHALL have port wr_block input 1: suppresses the HI/LO write in the cycle it is high.
REQ-009 SHALL have port busy output 1: an operation is in flight.
REQ-010 SHALL have port done output 1: one-cycle completion pulse.
REQ-011 SHALL have ports hi_rdata and lo_rdata, each output WIDTH: current HI and LO register contents.

Function
REQ-012 SHALL have states IDLE, MUL, DIV, DONE; busy = (state != IDLE); done = (state == DONE).
REQ-013 SHALL drive req_ready = (state == IDLE) && !cancel; it SHALL latch op and operands on the accept edge.
REQ-014 On MTHI/MTLO accept, SHALL write req_src1 to HI/LO on the accept edge and go IDLE->DONE.
REQ-015 On NOP accept, SHALL go IDLE->DONE and write nothing.
REQ-016 On MULT/MULTU accept, SHALL go IDLE->MUL.
REQ-017 In MUL, SHALL form the 2*WIDTH-bit product (signed for MULT, unsigned for MULTU) on the next edge, write HI=upper and LO=lower halves, and go MUL->DONE; done is high 2 cycles after accept.
REQ-018 On DIV/DIVU accept, SHALL load magnitudes (absolute values for DIV) and a counter = WIDTH, and go IDLE->DIV.
REQ-019 In DIV, SHALL perform one restoring shift-subtract quotient bit per cycle, decrementing the counter.
REQ-020 On the counter-1 cycle, SHALL apply sign fix (quotient negated iff operand signs differ; remainder takes the dividend sign), write LO=quotient and HI=remainder, and go DIV->DONE; done is high WIDTH+1 cycles after accept.
REQ-021 DIV with most-negative / -1 SHALL yield LO = most-negative and HI = 0 (wraps, no trap).
REQ-022 A divisor of zero SHALL leave HI/LO unwritten while keeping normal latency and the done pulse.
REQ-023 DONE SHALL always go to IDLE on the next edge; no request is accepted in DONE.
REQ-024 cancel high in MUL or DIV SHALL force state to IDLE on the next edge, with no HI/LO write and no done pulse.
REQ-025 cancel in DONE SHALL be ignored, because the result is already committed.
REQ-026 cancel in IDLE SHALL block acceptance.
REQ-027 wr_block high on a write edge SHALL suppress the write only; state sequencing and done are unaffected.
REQ-028 Writes from cancel/wr_block-free cycles SHALL be visible on hi_rdata/lo_rdata the cycle after the write edge.

Reset
REQ-029 On reset, SHALL set state=IDLE, HI=0, LO=0, counter=0, busy=0, done=0; req_ready=1 when cancel is low.
REQ-030 Reset SHALL override any in-flight operation, with no write at that edge.

Verification
REQ-031 SHALL verify: MULT src1=0xFFFFFFFD, src2=5 -> done at accept+2, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-032 SHALL verify: DIVU 100/7 -> done at accept+33, LO=14, HI=2; DIV 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 SHALL verify: DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU x/0 -> done at accept+33, HI/LO unchanged.
REQ-034 SHALL verify: cancel pulsed 10 cycles into a DIV -> busy=0 next cycle, no done, HI/LO unchanged, next request accepted in the following cycle.
REQ-035 SHALL verify: MTHI 0x12345678 with wr_block=1 -> done pulses, HI unchanged; repeated with wr_block=0 -> HI=0x12345678.
REQ-036 SHALL verify: reset asserted mid-MUL -> HI=LO=0, busy=0, done=0, req_ready=1 next cycle.
